// File: rtl/bcd_7seg_scanner.sv
// rtl/bcd_7seg_scanner.sv - multiplexed common-anode 7-segment scanner for packed BCD (option: LEADING_ZERO_BLANK_EN)
module bcd_7seg_scanner #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  err,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(CLK_DIV);

  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] val;

  logic                pre_wrap;
  logic                idx_last;
  logic [3:0]          nib;
  logic                any_bad;
  logic                blank;
  logic [6:0]          dec;
  logic [6:0]          seg_d;
  logic [DIGITS-1:0]   an_d;

  // Scan bookkeeping, nibble select and the error flag over every latched digit
  always_comb begin
    pre_wrap = (pre == PRE_W'(CLK_DIV - 1));
    idx_last = (idx == IDX_W'(DIGITS - 1));
    nib      = 4'd0;
    any_bad  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) nib = val[4*i +: 4];
      if (val[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // Leading-zero blanking: digit idx>=1 goes dark when it and every higher nibble are zero
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if ((IDX_W'(i) >= idx) && (val[4*i +: 4] != 4'd0)) blank = 1'b0;
    end
`else
    blank = 1'b0;
`endif
  end

  // Active-low segment decode {g,f,e,d,c,b,a}; non-BCD nibbles show a dash
  always_comb begin
    case (nib)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
    seg_d = blank ? 7'b1111111 : dec;
    an_d  = ~(DIGITS'(1) << idx);
  end

  // State and registered outputs; outputs lag idx/val by one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      pre        <= '0;
      idx        <= '0;
      val        <= '0;
      seg        <= 7'b1111111;
      an         <= '1;
      err        <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      if (load) val <= bcd_in;
      if (pre_wrap) begin
        pre <= '0;
        idx <= idx_last ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      seg        <= seg_d;
      an         <= an_d;
      err        <= any_bad;
      frame_tick <= pre_wrap && idx_last;
    end
  end

endmodule
